data_mem_responder: RTL and testbench

Word-organised data memory that answers the core's load/store unit. It accepts one request at a time: an active-low chip select, an active-low write enable, a 4-bit byte-lane mask, a byte address and write data. After a parameterised number of wait states it commits byte-masked writes, or returns the raw aligned 32-bit word for loads; the load/store unit performs sign/zero extension. It sits between the load/store unit and the writeback mux, and replaces the zero-latency array with a handshake that tolerates wait states.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/byte_ram.sv | 29 ++
 rtl/data_mem_responder.sv | 141 ++++++++++++++
 tb/tb_data_mem_responder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the data memory responder and its load/store unit peers.
// Holds the responder FSM encoding, LSU opcodes and the standard byte-lane masks.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [3:0] MASK_B0 = 4'b0001;
    localparam logic [3:0] MASK_B1 = 4'b0010;
    localparam logic [3:0] MASK_B2 = 4'b0100;
    localparam logic [3:0] MASK_B3 = 4'b1000;
    localparam logic [3:0] MASK_H0 = 4'b0011;
    localparam logic [3:0] MASK_H1 = 4'b1100;
    localparam logic [3:0] MASK_W  = 4'b1111;

endpackage

// File: rtl/byte_ram.sv
// Word-wide RAM built from four byte lanes with per-lane write enables.
// Latency: one cycle synchronous read, gated by re; output holds when re is low.
// Backpressure: none, one access per cycle; contents are never reset.
module byte_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] idx,
    input  logic [3:0]    we,
    input  logic          re,
    input  logic [31:0]   wdat,
    output logic [31:0]   rdat
);

    logic [3:0][7:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[idx][i] <= wdat[8*i +: 8];
            end
        end
        if (re) begin
            rdat <= mem[idx];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data memory answering the load/store unit: byte-masked stores, raw aligned word loads.
// Latency: commit and one-cycle ready pulse LATENCY cycles after acceptance (LATENCY+2 per access).
// Backpressure: one request at a time; initiator holds cs low with stable fields until ready.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs,
    input  logic        wr_en,
    input  logic [3:0]  mask,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam bit         ZERO_LAT = (LATENCY == 0);
    localparam logic [3:0] LAT4     = 4'(LATENCY);

    state_t      state;
    logic [3:0]  cnt;
    logic        wr_en_q;
    logic [3:0]  mask_q;
    logic [29:0] widx_q;
    logic [31:0] wdata_q;
    logic        rd_zero;

    logic        req_ld;
    logic [3:0]  req_mask;
    logic [29:0] req_widx;
    logic [31:0] req_wdata;
    logic        accept;
    logic        commit;
    logic        oor;
    logic [3:0]  ram_we;
    logic        ram_re;
    logic [31:0] ram_q;
    logic [1:0]  unused_addr_lsb;

    assign unused_addr_lsb = addr[1:0];

    // With zero wait states the commit happens on the acceptance edge, so the live inputs are used.
    always_comb begin
        req_ld    = wr_en_q;
        req_mask  = mask_q;
        req_widx  = widx_q;
        req_wdata = wdata_q;
        if (state == IDLE) begin
            req_ld    = wr_en;
            req_mask  = mask;
            req_widx  = addr[31:2];
            req_wdata = wdata;
        end
    end

    assign accept = (state == IDLE) && !cs;
    assign commit = rst_n && ((accept && ZERO_LAT) || ((state == WAIT) && (cnt == 4'd0)));
    assign oor    = {2'b00, req_widx} >= 32'(DEPTH_WORDS);
    assign ram_we = (commit && !req_ld && !oor) ? req_mask : 4'b0000;
    assign ram_re = commit && req_ld && !oor;

    byte_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk  (clk),
        .idx  (req_widx[AW-1:0]),
        .we   (ram_we),
        .re   (ram_re),
        .wdat (req_wdata),
        .rdat (ram_q)
    );

    // The RAM output register is not reset; rd_zero masks it after reset and for out-of-range loads.
    assign rdata = rd_zero ? 32'd0 : ram_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            wr_en_q <= 1'b1;
            mask_q  <= 4'd0;
            widx_q  <= 30'd0;
            wdata_q <= 32'd0;
            rd_zero <= 1'b1;
            ready   <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            if (commit && req_ld) begin
                rd_zero <= oor;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        wr_en_q <= wr_en;
                        mask_q  <= mask;
                        widx_q  <= addr[31:2];
                        wdata_q <= wdata;
                        busy    <= 1'b1;
                        if (ZERO_LAT) begin
                            state <= RESP;
                            ready <= 1'b1;
                            err   <= oor;
                        end else begin
                            state <= WAIT;
                            cnt   <= LAT4 - 4'd1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                        ready <= 1'b1;
                        err   <= oor;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances with LATENCY 2, 0 and 4 share request fields.
module tb_data_mem_responder;

    logic        clk;
    logic        rst_n;
    logic [2:0]  cs_v;
    logic        wr_en;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata_v [3];
    logic [2:0]  ready_v;
    logic [2:0]  busy_v;
    logic [2:0]  err_v;

    int tests = 0;
    int fails = 0;

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut_l2 (
        .clk(clk), .rst_n(rst_n), .cs(cs_v[0]), .wr_en(wr_en), .mask(mask), .addr(addr),
        .wdata(wdata), .rdata(rdata_v[0]), .ready(ready_v[0]), .busy(busy_v[0]), .err(err_v[0])
    );
    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) dut_l0 (
        .clk(clk), .rst_n(rst_n), .cs(cs_v[1]), .wr_en(wr_en), .mask(mask), .addr(addr),
        .wdata(wdata), .rdata(rdata_v[1]), .ready(ready_v[1]), .busy(busy_v[1]), .err(err_v[1])
    );
    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) dut_l4 (
        .clk(clk), .rst_n(rst_n), .cs(cs_v[2]), .wr_en(wr_en), .mask(mask), .addr(addr),
        .wdata(wdata), .rdata(rdata_v[2]), .ready(ready_v[2]), .busy(busy_v[2]), .err(err_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int k);
        case (k)
            0:       return 2;
            1:       return 0;
            default: return 4;
        endcase
    endfunction

    // Issues one request on instance k and waits (bounded) for its ready pulse.
    task automatic access(input int k, input logic st, input logic [3:0] m,
                          input logic [31:0] a, input logic [31:0] d, input bit churn,
                          output logic [31:0] rd, output logic e, output int lat);
        bit got = 0;
        rd  = 32'hX;
        e   = 1'bX;
        lat = 0;
        @(negedge clk);
        wr_en = ~st; mask = m; addr = a; wdata = d;
        cs_v[k] = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (ready_v[k]) begin
                got = 1;
                rd  = rdata_v[k];
                e   = err_v[k];
            end else if (churn && i == 0) begin
                addr  = a + 32'd4;
                wdata = ~d;
            end
        end
        cs_v[k] = 1'b1;
        chk($sformatf("ready_seen_k%0d_a%h", k, a), {31'd0, got}, 32'd1);
    endtask

    task automatic do_st(input int k, input logic [3:0] m, input logic [31:0] a,
                         input logic [31:0] d, input logic exp_err, input bit churn);
        logic [31:0] rd;
        logic e;
        int lat;
        access(k, 1'b1, m, a, d, churn, rd, e, lat);
        chk($sformatf("st_err_k%0d_a%h", k, a), {31'd0, e}, {31'd0, exp_err});
        chk($sformatf("st_lat_k%0d_a%h", k, a), 32'(lat), 32'(lat_of(k) + 1));
    endtask

    task automatic do_ld(input int k, input logic [31:0] a, input logic [31:0] exp,
                         input logic exp_err);
        logic [31:0] rd;
        logic e;
        int lat;
        access(k, 1'b0, 4'b0000, a, 32'h0, 1'b0, rd, e, lat);
        chk($sformatf("ld_data_k%0d_a%h", k, a), rd, exp);
        chk($sformatf("ld_err_k%0d_a%h", k, a), {31'd0, e}, {31'd0, exp_err});
    endtask

    logic [31:0] l0_addr [4];
    logic [31:0] l0_val  [4];
    int          pulses;

    initial begin
        rst_n = 1'b0; cs_v = 3'b111; wr_en = 1'b1; mask = 4'h0; addr = 32'h0; wdata = 32'h0;
        l0_addr = '{32'h0, 32'h4, 32'h8, 32'hC};
        l0_val  = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_rdata_k%0d", k), rdata_v[k], 32'h0);
            chk($sformatf("rst_ready_k%0d", k), {31'd0, ready_v[k]}, 32'd0);
            chk($sformatf("rst_busy_k%0d", k), {31'd0, busy_v[k]}, 32'd0);
            chk($sformatf("rst_err_k%0d", k), {31'd0, err_v[k]}, 32'd0);
        end
        rst_n = 1'b1;

        // Word store then load, LATENCY 2.
        do_st(0, 4'b1111, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0);
        do_ld(0, 32'h10, 32'hDEADBEEF, 1'b0);

        // Byte and halfword lanes; a store leaves rdata untouched.
        do_st(0, 4'b1111, 32'h20, 32'h11223344, 1'b0, 1'b0);
        do_st(0, 4'b0100, 32'h20, 32'h00AB0000, 1'b0, 1'b0);
        do_ld(0, 32'h20, 32'h11AB3344, 1'b0);
        do_st(0, 4'b1100, 32'h20, 32'hCAFE0000, 1'b0, 1'b0);
        chk("rdata_hold_after_store", rdata_v[0], 32'h11AB3344);
        do_ld(0, 32'h20, 32'hCAFE3344, 1'b0);

        // Empty mask completes without writing; ignored low address bits.
        do_st(0, 4'b0000, 32'h10, 32'h12345678, 1'b0, 1'b0);
        do_ld(0, 32'h13, 32'hDEADBEEF, 1'b0);

        // Out of range: 0x1000 would alias word 0 if the range check were missing.
        do_st(0, 4'b1111, 32'h0, 32'h01020304, 1'b0, 1'b0);
        do_st(0, 4'b1111, 32'h1000, 32'hFFFFFFFF, 1'b1, 1'b0);
        do_ld(0, 32'h0, 32'h01020304, 1'b0);
        do_ld(0, 32'h1000, 32'h0, 1'b1);
        @(negedge clk);
        chk("err_low_after_ready", {31'd0, err_v[0]}, 32'd0);
        chk("oor_rdata_held", rdata_v[0], 32'h0);

        // Input churn during WAIT must not reach memory.
        do_st(0, 4'b1111, 32'h44, 32'h2468ACE0, 1'b0, 1'b0);
        do_st(0, 4'b1111, 32'h40, 32'h13579BDF, 1'b0, 1'b1);
        do_ld(0, 32'h40, 32'h13579BDF, 1'b0);
        do_ld(0, 32'h44, 32'h2468ACE0, 1'b0);

        // LATENCY 0 back-to-back loads with cs held low.
        for (int i = 0; i < 4; i++) do_st(1, 4'b1111, l0_addr[i], l0_val[i], 1'b0, 1'b0);
        @(negedge clk);
        wr_en = 1'b1; addr = l0_addr[0]; cs_v[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("b2b_ready_%0d", i), {31'd0, ready_v[1]}, 32'd1);
            chk($sformatf("b2b_busy_%0d", i), {31'd0, busy_v[1]}, 32'd1);
            chk($sformatf("b2b_rdata_%0d", i), rdata_v[1], l0_val[i]);
            if (i < 3) addr = l0_addr[i+1];
            else cs_v[1] = 1'b1;
            @(negedge clk);
            chk($sformatf("b2b_gap_ready_%0d", i), {31'd0, ready_v[1]}, 32'd0);
            chk($sformatf("b2b_gap_busy_%0d", i), {31'd0, busy_v[1]}, 32'd0);
        end

        // Reset two edges into a LATENCY 4 store: nothing commits, old data survives.
        do_st(2, 4'b1111, 32'h30, 32'h0F0E0D0C, 1'b0, 1'b0);
        do_ld(2, 32'h30, 32'h0F0E0D0C, 1'b0);
        @(negedge clk);
        wr_en = 1'b0; mask = 4'b1111; addr = 32'h30; wdata = 32'h55AA55AA; cs_v[2] = 1'b0;
        @(negedge clk);
        chk("midwait_busy", {31'd0, busy_v[2]}, 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_busy", {31'd0, busy_v[2]}, 32'd0);
        chk("rst_async_ready", {31'd0, ready_v[2]}, 32'd0);
        chk("rst_async_rdata", rdata_v[2], 32'h0);
        cs_v[2] = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ready_v[2]) pulses++;
        end
        chk("no_ready_after_reset", 32'(pulses), 32'd0);
        do_ld(2, 32'h30, 32'h0F0E0D0C, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
